// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU core, the port arbiter and the single-port RAM.
// master = core/RAM side, slave = arbiter side.
interface mem_port_arbiter_if;
    logic        p0_req;
    logic [31:0] p0_addr;
    logic        p0_ready;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p0_err;

    logic        p1_req;
    logic [31:0] p1_addr;
    logic        p1_we;
    logic [31:0] p1_wdata;
    logic [3:0]  p1_be;
    logic        p1_ready;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    logic        p1_err;

    logic [31:0] mem_address;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output p0_req, p0_addr,
        input  p0_ready, p0_rvalid, p0_rdata, p0_err,
        output p1_req, p1_addr, p1_we, p1_wdata, p1_be,
        input  p1_ready, p1_rvalid, p1_rdata, p1_err,
        input  mem_address, mem_write_en, mem_write_data,
        output mem_read_data
    );

    modport slave (
        input  p0_req, p0_addr,
        output p0_ready, p0_rvalid, p0_rdata, p0_err,
        input  p1_req, p1_addr, p1_we, p1_wdata, p1_be,
        output p1_ready, p1_rvalid, p1_rdata, p1_err,
        output mem_address, mem_write_en, mem_write_data,
        input  mem_read_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (fetch + load/store) onto one word-write RAM, with RMW for partial stores.
// Define ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed priority p1 over p0.
module mem_port_arbiter #(
    parameter int NUM_OF_BYTES = 800
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, RESP} state_t;

    localparam logic [31:0] MAX_ADDR = 32'(NUM_OF_BYTES - 4);

    state_t      state_q, state_d;
    logic        port_q, port_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] old_q, old_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic        prio_q, prio_d;
`endif

    logic        grant0, grant1;
    logic        in_range, full_be, zero_be;
    logic [31:0] merged;

    assign in_range = (addr_q <= MAX_ADDR);
    assign full_be  = (be_q == 4'b1111);
    assign zero_be  = (be_q == 4'b0000);

    // Pick at most one winner while idle; ready is the grant itself.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && state_q == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant1 = bus.p1_req && (!bus.p0_req || prio_q);
`else
            grant1 = bus.p1_req;
`endif
            grant0 = bus.p0_req && !grant1;
        end
    end

    // Merge new store lanes over the old word for the RMW write.
    always_comb begin
        merged = old_q;
        for (int k = 0; k < 4; k++) begin
            if (be_q[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
        end
    end

    // Next-state and latched request/response.
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        old_d   = old_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef ARB_ROUND_ROBIN_EN
        prio_d  = prio_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d = ACCESS;
                    port_d  = grant1;
                    addr_d  = grant1 ? bus.p1_addr : bus.p0_addr;
                    we_d    = grant1 && bus.p1_we;
                    wdata_d = grant1 ? bus.p1_wdata : 32'h0;
                    be_d    = grant1 ? bus.p1_be : 4'h0;
`ifdef ARB_ROUND_ROBIN_EN
                    prio_d  = !grant1;
`endif
                end
            end
            ACCESS: begin
                state_d = RESP;
                rdata_d = 32'h0;
                err_d   = 1'b0;
                if (!in_range) begin
                    err_d = 1'b1;
                end else if (!we_q) begin
                    rdata_d = bus.mem_read_data;
                end else if (!full_be && !zero_be) begin
                    old_d   = bus.mem_read_data;
                    state_d = RMW_WR;
                end
            end
            RMW_WR:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            port_q  <= 1'b0;
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            old_q   <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            prio_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            old_q   <= old_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
            prio_q  <= prio_d;
`endif
        end
    end

    // Drive handshakes and RAM; everything is forced quiet during reset.
    always_comb begin
        bus.p0_ready       = grant0;
        bus.p1_ready       = grant1;
        bus.p0_rvalid      = 1'b0;
        bus.p0_rdata       = 32'h0;
        bus.p0_err         = 1'b0;
        bus.p1_rvalid      = 1'b0;
        bus.p1_rdata       = 32'h0;
        bus.p1_err         = 1'b0;
        bus.mem_address    = 32'h0;
        bus.mem_write_en   = 1'b0;
        bus.mem_write_data = 32'h0;
        if (!reset) begin
            if (state_q != IDLE) bus.mem_address = addr_q;
            if (state_q == ACCESS && we_q && in_range && full_be) begin
                bus.mem_write_en   = 1'b1;
                bus.mem_write_data = wdata_q;
            end
            if (state_q == RMW_WR) begin
                bus.mem_write_en   = 1'b1;
                bus.mem_write_data = merged;
            end
            if (state_q == RESP) begin
                if (port_q) begin
                    bus.p1_rvalid = 1'b1;
                    bus.p1_rdata  = rdata_q;
                    bus.p1_err    = err_q;
                end else begin
                    bus.p0_rvalid = 1'b1;
                    bus.p0_rdata  = rdata_q;
                    bus.p0_err    = err_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model, cycle-level reference model and
// directed transactions with hand-computed results.
module tb_mem_port_arbiter;

    localparam int NB = 800;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.NUM_OF_BYTES(NB)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [7:0] ram [NB];
    logic [7:0] ref_mem [NB];
    int total = 0;
    int passed = 0;
    int wr_pulses = 0;
    int grants[$];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [31:0] ram_word(input int a);
        return {ram[a+3], ram[a+2], ram[a+1], ram[a]};
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    // RAM: combinational read, Z past the end, synchronous word write.
    always_comb begin
        bus.mem_read_data = 'z;
        if (bus.mem_address <= 32'(NB - 4))
            bus.mem_read_data = ram_word(int'(bus.mem_address));
    end

    always @(posedge clk) begin
        if (bus.mem_write_en) begin
            wr_pulses <= wr_pulses + 1;
            if (bus.mem_address <= 32'(NB - 4)) begin
                for (int k = 0; k < 4; k++)
                    ram[int'(bus.mem_address) + k] <= bus.mem_write_data[8*k +: 8];
            end
        end
    end

    // Reference model: per-transaction timeline from the accept cycle.
    initial begin : compare
        int cyc, free_c, resp_c, wr_c;
        bit pend, pport, last, w0, w1, pwe, inr;
        logic [31:0] paddr, erd, ewd, wd, old, eaddr;
        logic [3:0] be;
        bit eerr;
        cyc = 0; free_c = 0; resp_c = 0; wr_c = -1;
        pend = 0; pport = 0; last = 0;
        paddr = 0; erd = 0; ewd = 0; eerr = 0;
        forever begin
            @(negedge clk);
            if (pend && cyc > resp_c) pend = 0;
            if (reset) begin
                chk("rst_p0_ready", 32'(bus.p0_ready), 0);
                chk("rst_p1_ready", 32'(bus.p1_ready), 0);
                chk("rst_p0_rvalid", 32'(bus.p0_rvalid), 0);
                chk("rst_p1_rvalid", 32'(bus.p1_rvalid), 0);
                chk("rst_p0_rdata", bus.p0_rdata, 0);
                chk("rst_p1_rdata", bus.p1_rdata, 0);
                chk("rst_p0_err", 32'(bus.p0_err), 0);
                chk("rst_p1_err", 32'(bus.p1_err), 0);
                chk("rst_mem_address", bus.mem_address, 0);
                chk("rst_mem_write_en", 32'(bus.mem_write_en), 0);
                chk("rst_mem_write_data", bus.mem_write_data, 0);
                pend = 0;
                free_c = cyc + 1;
                last = 0;
            end else begin
                eaddr = pend ? paddr : 32'h0;
                chk("mem_address", bus.mem_address, eaddr);
                if (pend && cyc == wr_c) begin
                    chk("mem_write_en", 32'(bus.mem_write_en), 1);
                    chk("mem_write_data", bus.mem_write_data, ewd);
                    for (int k = 0; k < 4; k++)
                        ref_mem[int'(paddr) + k] = ewd[8*k +: 8];
                end else begin
                    chk("mem_write_en", 32'(bus.mem_write_en), 0);
                end
                chk("p0_rvalid", 32'(bus.p0_rvalid),
                    32'(pend && cyc == resp_c && !pport));
                chk("p1_rvalid", 32'(bus.p1_rvalid),
                    32'(pend && cyc == resp_c && pport));
                if (pend && cyc == resp_c) begin
                    if (pport) begin
                        chk("p1_rdata", bus.p1_rdata, erd);
                        chk("p1_err", 32'(bus.p1_err), 32'(eerr));
                    end else begin
                        chk("p0_rdata", bus.p0_rdata, erd);
                        chk("p0_err", 32'(bus.p0_err), 32'(eerr));
                    end
                end
                w0 = 0;
                w1 = 0;
                if (!pend && cyc >= free_c) begin
                    if (bus.p1_req && bus.p0_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                        w1 = !last;
`else
                        w1 = 1;
`endif
                    end else begin
                        w1 = bus.p1_req;
                    end
                    w0 = bus.p0_req && !w1;
                end
                chk("p0_ready", 32'(bus.p0_ready), 32'(w0));
                chk("p1_ready", 32'(bus.p1_ready), 32'(w1));
                if (w0 || w1) begin
                    pport = w1;
                    last = w1;
                    paddr = w1 ? bus.p1_addr : bus.p0_addr;
                    pwe = w1 && bus.p1_we;
                    wd = bus.p1_wdata;
                    be = bus.p1_be;
                    inr = (paddr <= 32'(NB - 4));
                    wr_c = -1;
                    erd = 0;
                    eerr = 0;
                    resp_c = cyc + 2;
                    if (!inr) begin
                        eerr = 1;
                    end else if (!pwe) begin
                        erd = ref_word(int'(paddr));
                    end else if (be == 4'hF) begin
                        ewd = wd;
                        wr_c = cyc + 1;
                    end else if (be != 4'h0) begin
                        old = ref_word(int'(paddr));
                        for (int k = 0; k < 4; k++)
                            ewd[8*k +: 8] = be[k] ? wd[8*k +: 8] : old[8*k +: 8];
                        wr_c = cyc + 2;
                        resp_c = cyc + 3;
                    end
                    free_c = resp_c + 1;
                    pend = 1;
                end
            end
            cyc++;
        end
    end

    // One transaction; starts just after a posedge, returns just after one.
    task automatic xact(input bit port, input logic [31:0] addr,
                        input bit we, input logic [31:0] wd,
                        input logic [3:0] be, input int abort_at,
                        output int waitc, output int lat,
                        output logic [31:0] rd, output logic er);
        bit got;
        got = 0;
        waitc = -1;
        lat = 0;
        rd = 'x;
        er = 'x;
        if (port) begin
            bus.p1_req = 1;
            bus.p1_addr = addr;
            bus.p1_we = we;
            bus.p1_wdata = wd;
            bus.p1_be = be;
        end else begin
            bus.p0_req = 1;
            bus.p0_addr = addr;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (port ? bus.p1_ready : bus.p0_ready) begin
                got = 1;
                waitc = i;
            end
        end
        @(posedge clk);
        #1;
        bus.p0_req = 0;
        bus.p1_req = 0;
        if (!got) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        if (abort_at > 0) begin
            repeat (abort_at) @(posedge clk);
            #1 reset = 1;
            @(negedge clk);
            chk("abort_write_en", 32'(bus.mem_write_en), 0);
            chk("abort_rvalid", 32'(bus.p1_rvalid), 0);
            @(posedge clk);
            #1 reset = 0;
            return;
        end
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (port ? bus.p1_rvalid : bus.p0_rvalid) begin
                lat = i;
                rd = port ? bus.p1_rdata : bus.p0_rdata;
                er = port ? bus.p1_err : bus.p0_err;
                break;
            end
        end
        if (lat == 0) chk("rvalid_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int waitc, lat, p0c;
        logic [31:0] rd;
        logic er;
        logic [2:0] eg;
        for (int i = 0; i < NB; i++) begin
            ram[i] = 8'(i);
            ref_mem[i] = 8'(i);
        end
        ram[0] = 8'h05; ram[1] = 8'h50; ram[2] = 8'hA0; ram[3] = 8'hE3;
        ref_mem[0] = 8'h05; ref_mem[1] = 8'h50;
        ref_mem[2] = 8'hA0; ref_mem[3] = 8'hE3;
        bus.p0_req = 0;
        bus.p0_addr = 0;
        bus.p1_req = 0;
        bus.p1_addr = 0;
        bus.p1_we = 0;
        bus.p1_wdata = 0;
        bus.p1_be = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        xact(0, 32'h0, 0, 0, 0, 0, waitc, lat, rd, er);
        chk("fetch0_ready_cycle", 32'(waitc), 0);
        chk("fetch0_latency", 32'(lat), 2);
        chk("fetch0_rdata", rd, 32'hE3A05005);
        chk("fetch0_err", 32'(er), 0);

        p0c = wr_pulses;
        xact(1, 32'h10, 1, 32'hDEADBEEF, 4'hF, 0, waitc, lat, rd, er);
        chk("store_full_latency", 32'(lat), 2);
        chk("store_full_pulses", 32'(wr_pulses - p0c), 1);
        chk("store_full_rdata", rd, 0);
        chk("store_full_ram", ram_word(16), 32'hDEADBEEF);
        xact(1, 32'h10, 0, 0, 0, 0, waitc, lat, rd, er);
        chk("load10_rdata", rd, 32'hDEADBEEF);

        p0c = wr_pulses;
        xact(1, 32'h10, 1, 32'h000000AA, 4'b0001, 0, waitc, lat, rd, er);
        chk("rmw_latency", 32'(lat), 3);
        chk("rmw_pulses", 32'(wr_pulses - p0c), 1);
        chk("rmw_ram", ram_word(16), 32'hDEADBEAA);

        p0c = wr_pulses;
        xact(1, 32'h10, 1, 32'h12345678, 4'b0000, 0, waitc, lat, rd, er);
        chk("zero_be_latency", 32'(lat), 2);
        chk("zero_be_pulses", 32'(wr_pulses - p0c), 0);
        xact(1, 32'h11, 0, 0, 0, 0, waitc, lat, rd, er);
        chk("unaligned_load", rd, 32'h14DEADBE);

        bus.p0_req = 1;
        bus.p0_addr = 32'h0;
        bus.p1_req = 1;
        bus.p1_addr = 32'h10;
        bus.p1_we = 0;
        bus.p1_be = 0;
        for (int i = 0; i < 30 && grants.size() < 3; i++) begin
            @(negedge clk);
            if (bus.p1_ready) grants.push_back(1);
            else if (bus.p0_ready) grants.push_back(0);
        end
        @(posedge clk);
        #1;
        bus.p0_req = 0;
        bus.p1_req = 0;
        repeat (4) @(posedge clk);
        #1;
`ifdef ARB_ROUND_ROBIN_EN
        eg = 3'b101;
`else
        eg = 3'b111;
`endif
        chk("grant_count", 32'(grants.size()), 3);
        for (int k = 0; k < grants.size() && k < 3; k++)
            chk("grant_order", 32'(grants[k]), 32'(eg[2-k]));

        p0c = wr_pulses;
        xact(1, 32'd797, 1, 32'hCAFEF00D, 4'hF, 0, waitc, lat, rd, er);
        chk("oor_store_pulses", 32'(wr_pulses - p0c), 0);
        chk("oor_store_err", 32'(er), 1);
        chk("oor_store_rdata", rd, 0);
        xact(0, 32'd796, 0, 0, 0, 0, waitc, lat, rd, er);
        chk("fetch796_err", 32'(er), 0);
        chk("fetch796_rdata", rd, 32'h1F1E1D1C);
        xact(1, 32'hFFFFFFFF, 0, 0, 0, 0, waitc, lat, rd, er);
        chk("oor_wrap_err", 32'(er), 1);
        chk("oor_wrap_rdata", rd, 0);

        p0c = wr_pulses;
        xact(1, 32'h10, 1, 32'h00005500, 4'b0010, 1, waitc, lat, rd, er);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_pulses", 32'(wr_pulses - p0c), 0);
        chk("abort_ram", ram_word(16), 32'hDEADBEAA);
        xact(0, 32'h0, 0, 0, 0, 0, waitc, lat, rd, er);
        chk("post_abort_ready", 32'(waitc), 0);
        chk("post_abort_latency", 32'(lat), 2);
        chk("post_abort_rdata", rd, 32'hE3A05005);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
